// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
// Optional macro MULDIV_EN enables mult/div (and immediate forms) with alu_done wait.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_done,
    input  logic       zero,
    input  logic       gt,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_start,
    output logic       alu_src_imm,
    output logic [4:0] alu_op,
    output logic       reg_we,
    output logic       wb_sel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       retire
);

`ifdef MULDIV_EN
    localparam logic MULDIV_ON = 1'b1;
`else
    localparam logic MULDIV_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic legal;
        logic alu;
        logic muldiv;
        logic imm;
        logic slt;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic bgt;
        logic jr;
        logic j;
    } dec_t;

    function automatic dec_t decode_op(input logic [4:0] op);
        dec_t d;
        d = '0;
        case (op)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101: d.alu = 1'b1;
            5'b01001, 5'b01010, 5'b01100, 5'b01101: begin
                d.alu = 1'b1;
                d.imm = 1'b1;
            end
            5'b00110, 5'b00111: begin
                d.alu    = MULDIV_ON;
                d.muldiv = MULDIV_ON;
            end
            5'b01110, 5'b01111: begin
                d.alu    = MULDIV_ON;
                d.muldiv = MULDIV_ON;
                d.imm    = MULDIV_ON;
            end
            5'b10000: d.bgt = 1'b1;
            5'b10001: d.slt = 1'b1;
            5'b10010: d.lw  = 1'b1;
            5'b10011: d.sw  = 1'b1;
            5'b10100: d.beq = 1'b1;
            5'b10101: d.bne = 1'b1;
            5'b10110: d.jr  = 1'b1;
            5'b10111: d.j   = 1'b1;
            default: ;
        endcase
        d.legal = d.alu | d.slt | d.lw | d.sw | d.beq | d.bne | d.bgt | d.jr | d.j;
        return d;
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [4:0] op_q;
    logic       illegal_q;
    logic       exec_first_q;
    dec_t       dec_in;
    dec_t       dec_q;

    // DECODE classifies the live opcode; later states use the latched copy.
    assign dec_in = decode_op(opcode);
    assign dec_q  = decode_op(op_q);
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            op_q         <= 5'b00000;
            illegal_q    <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= (state_q == S_DECODE);
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                if (!dec_in.legal) illegal_q <= 1'b1;
            end
        end
    end

    // Memory handshake: mem_req is held while waiting; the access completes in any
    // cycle where mem_req=1 and mem_ready=1, including the cycle mem_req first rises.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_start   = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 5'd0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        illegal     = illegal_q;
        retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_in.legal) begin
                    state_d = S_HALT;
                end else if (dec_in.j) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op      = {dec_q.jr, dec_q.beq | dec_q.bne, dec_q.lw | dec_q.sw,
                               dec_q.slt, dec_q.alu};
                alu_src_imm = dec_q.imm | dec_q.lw | dec_q.sw;
                alu_start   = exec_first_q;
                if (dec_q.muldiv) begin
                    if (alu_done) state_d = S_WB;
                end else if (dec_q.alu || dec_q.slt) begin
                    state_d = S_WB;
                end else if (dec_q.lw || dec_q.sw) begin
                    state_d = S_MEM;
                end else if (dec_q.jr) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd3;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if ((dec_q.beq && zero) || (dec_q.bne && !zero) || (dec_q.bgt && gt)) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                    end
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = dec_q.sw;
                if (mem_ready) begin
                    if (dec_q.sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = dec_q.lw;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
        // Reset silences every strobe immediately, even mid-access.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 2'd0;
            alu_start   = 1'b0;
            alu_src_imm = 1'b0;
            alu_op      = 5'd0;
            reg_we      = 1'b0;
            wb_sel      = 1'b0;
            illegal     = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level trace builder produces expected per-cycle
// output vectors and stimulus; a replay loop drives and compares each cycle.
module tb_multicycle_ctrl;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam int C_ILL = 0, C_ALU = 1, C_MULDIV = 2, C_SLT = 3, C_LW = 4, C_SW = 5;
  localparam int C_BEQ = 6, C_BNE = 7, C_BGT = 8, C_JR = 9, C_J = 10;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_start;
    logic       alu_src_imm;
    logic [4:0] alu_op;
    logic       reg_we;
    logic       wb_sel;
    logic       illegal;
    logic       retire;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       alu_done;
    logic       zero;
    logic       gt;
  } stim_t;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic       mem_ready, alu_done, zero, gt;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_start, alu_src_imm;
  logic [4:0] alu_op;
  logic       reg_we, wb_sel;
  logic [2:0] state;
  logic       illegal, retire;

  stim_t       stim_q[$];
  logic [20:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .alu_done(alu_done), .zero(zero), .gt(gt), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_start(alu_start), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .retire(retire)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: instruction class from the opcode table
  function automatic int classify(input logic [4:0] op);
    logic [4:0] base;
    base = {op[4], 1'b0, op[2:0]};
    if (op inside {5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101}) return C_ALU;
    if (op inside {5'b00110, 5'b00111}) return MD ? C_MULDIV : C_ILL;
    if (op[4:3] == 2'b01 && (base inside {5'b00100, 5'b00101, 5'b00001, 5'b00010}))
      return C_ALU;
    if (op[4:3] == 2'b01 && (base inside {5'b00110, 5'b00111}))
      return MD ? C_MULDIV : C_ILL;
    case (op)
      5'b10000: return C_BGT;
      5'b10001: return C_SLT;
      5'b10010: return C_LW;
      5'b10011: return C_SW;
      5'b10100: return C_BEQ;
      5'b10101: return C_BNE;
      5'b10110: return C_JR;
      5'b10111: return C_J;
      default:  return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] exp_alu_op(input int k);
    case (k)
      C_ALU, C_MULDIV: return 5'b00001;
      C_SLT:           return 5'b00010;
      C_LW, C_SW:      return 5'b00100;
      C_BEQ, C_BNE:    return 5'b01000;
      C_JR:            return 5'b10000;
      default:         return 5'b00000;
    endcase
  endfunction

  function automatic stim_t rand_stim(input logic [4:0] op);
    stim_t s;
    s.rst       = 1'b0;
    s.opcode    = op;
    s.mem_ready = 1'($urandom_range(0, 1));
    s.alu_done  = 1'($urandom_range(0, 1));
    s.zero      = 1'($urandom_range(0, 1));
    s.gt        = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic logic [4:0] junk_op();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o = '{state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_start,
          alu_src_imm, alu_op, reg_we, wb_sel, illegal, retire};
    return o;
  endfunction

  // scoreboard compare
  task automatic check_cycle(input obs_t o, input logic [20:0] x, input string tag);
    checks++;
    if (o !== x) begin
      errors++;
      $error("FAIL %s @%0t: observed %b expected %b", tag, $time, o, x);
    end
  endtask

  // driver tasks: queue one cycle of stimulus with its expected outputs
  task automatic push(input stim_t s, input obs_t e, input string tag);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_reset(input logic [2:0] cur_state, input string tag);
    stim_t s;
    obs_t  e;
    s           = rand_stim(junk_op());
    s.rst       = 1'b1;
    s.mem_ready = 1'b1;
    e           = '0;
    e.state     = cur_state;
    push(s, e, tag);
  endtask

  // zf/gf: -1 = random, otherwise forced value during EXEC
  task automatic build_instr(input logic [4:0] op, input int fw, input int mw,
                             input int aw, input int zf, input int gf);
    stim_t s;
    obs_t  e;
    int    k;
    int    n;
    bit    taken;
    k = classify(op);
    for (int i = 0; i <= fw; i++) begin
      s = rand_stim(junk_op());
      s.mem_ready = (i == fw);
      e = '0;
      e.state = 3'd0;
      e.mem_req = 1'b1;
      if (i == fw) begin
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
      end
      push(s, e, "fetch");
    end
    s = rand_stim(op);
    e = '0;
    e.state = 3'd1;
    if (k == C_J) begin
      e.pc_we = 1'b1;
      e.pc_src = 2'd2;
      e.retire = 1'b1;
      push(s, e, "decode_j");
      return;
    end
    push(s, e, "decode");
    if (k == C_ILL) begin
      for (int i = 0; i < 12; i++) begin
        s = rand_stim(junk_op());
        e = '0;
        e.state = 3'd5;
        e.illegal = 1'b1;
        push(s, e, "halt");
      end
      push_reset(3'd5, "halt_rst");
      return;
    end
    n = (k == C_MULDIV) ? aw + 1 : 1;
    for (int i = 0; i < n; i++) begin
      s = rand_stim(junk_op());
      if (zf >= 0) s.zero = zf[0];
      if (gf >= 0) s.gt = gf[0];
      if (k == C_MULDIV) s.alu_done = (i == aw);
      e = '0;
      e.state = 3'd2;
      e.alu_op = exp_alu_op(k);
      e.alu_src_imm = (op[4:3] == 2'b01) || k == C_LW || k == C_SW;
      e.alu_start = (i == 0);
      if (k == C_JR) begin
        e.pc_we = 1'b1;
        e.pc_src = 2'd3;
        e.retire = 1'b1;
      end
      if (k == C_BEQ || k == C_BNE || k == C_BGT) begin
        taken = (k == C_BEQ) ? s.zero : (k == C_BNE) ? !s.zero : s.gt;
        e.retire = 1'b1;
        e.pc_we = taken;
        e.pc_src = taken ? 2'd1 : 2'd0;
      end
      push(s, e, "exec");
    end
    if (k == C_LW || k == C_SW) begin
      for (int i = 0; i <= mw; i++) begin
        s = rand_stim(junk_op());
        s.mem_ready = (i == mw);
        e = '0;
        e.state = 3'd3;
        e.mem_req = 1'b1;
        e.iord = 1'b1;
        e.mem_we = (k == C_SW);
        e.retire = (k == C_SW) && (i == mw);
        push(s, e, "mem");
      end
    end
    if (k == C_ALU || k == C_MULDIV || k == C_SLT || k == C_LW) begin
      s = rand_stim(junk_op());
      e = '0;
      e.state = 3'd4;
      e.reg_we = 1'b1;
      e.wb_sel = (k == C_LW);
      e.retire = 1'b1;
      push(s, e, "wb");
    end
  endtask

  initial begin
    stim_t       s;
    obs_t        obs;
    logic [20:0] x;
    string       tag;
    int          start;
    rst = 1'b1;
    opcode = '0;
    mem_ready = 1'b1;
    alu_done = 1'b1;
    zero = 1'b0;
    gt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cycle(sample_obs(), 21'd0, "initial_reset_state");

    push_reset(3'd0, "reset_state");
    build_instr(5'b00100, 0, 0, 0, -1, -1);
    build_instr(5'b10010, 1, 3, 0, -1, -1);
    build_instr(5'b10011, 0, 0, 0, -1, -1);
    build_instr(5'b10100, 0, 0, 0, 1, -1);
    build_instr(5'b10100, 0, 0, 0, 0, -1);
    build_instr(5'b10000, 0, 0, 0, -1, 1);
    build_instr(5'b10101, 0, 0, 0, 0, -1);
    build_instr(5'b10110, 2, 0, 0, -1, -1);
    build_instr(5'b10111, 0, 0, 0, -1, -1);
    build_instr(5'b00110, 0, 0, 5, -1, -1);
    build_instr(5'b01110, 0, 0, 0, -1, -1);
    build_instr(5'b11000, 0, 0, 0, -1, -1);
    start = stim_q.size();
    build_instr(5'b10011, 0, 5, 0, -1, -1);
    while (stim_q.size() > start + 5) begin
      void'(stim_q.pop_back());
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
    push_reset(3'd3, "mem_rst");
    for (int i = 0; i < 40; i++)
      build_instr(junk_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 4), -1, -1);

    @(posedge clk);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      tag = tag_q.pop_front();
      #1;
      rst = s.rst;
      opcode = s.opcode;
      mem_ready = s.mem_ready;
      alu_done = s.alu_done;
      zero = s.zero;
      gt = s.gt;
      @(negedge clk);
      obs = sample_obs();
      check_cycle(obs, x, tag);
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
